// File: rtl/master_in_port.sv
// master_in_port: reassembles LSB-first serial bytes from the slave return path and
// buffers them in a first-word-fall-through FIFO toward the master core.
module master_in_port #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_data,
  input  logic                       slave_valid,
  input  logic                       slave_tx_done,
  output logic                       master_ready,
  output logic [7:0]                 rx_byte,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic                       frame_error,
  output logic [CNT_W-1:0]           byte_count,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RECEIVE, GAP} state_e;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [6:0]       shreg_q, shreg_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0]       mem_q [DEPTH];
  logic             push, pop, full;

  assign full         = (lvl_q == LVL_W'(DEPTH));
  assign pop          = (lvl_q != '0) && rx_ready;
  assign master_ready = !reset && ((state_q == IDLE) || (state_q == GAP)) && !full;
  assign rx_byte      = mem_q[rd_q];
  assign rx_valid     = (lvl_q != '0);
  assign frame_error  = err_q;
  assign byte_count   = bcnt_q;
  assign fifo_level   = lvl_q;

  // Byte framing FSM; a byte only starts when a FIFO slot is free, so a push never overflows.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    err_d   = 1'b0;
    bcnt_d  = bcnt_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (slave_tx_done) begin
          err_d = 1'b1;
        end else if (slave_valid) begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            shreg_d[0] = rx_data;
            cnt_d      = 3'd1;
            state_d    = RECEIVE;
          end
        end
      end
      RECEIVE: begin
        if (!slave_valid) begin
          err_d   = 1'b1;
          cnt_d   = 3'd0;
          state_d = IDLE;
        end else begin
          if (cnt_q != 3'd7) shreg_d[cnt_q] = rx_data;
          if (slave_tx_done) begin
            if (cnt_q == 3'd7) begin
              push   = 1'b1;
              bcnt_d = bcnt_q + CNT_W'(1);
            end else begin
              err_d = 1'b1;
            end
            cnt_d   = 3'd0;
            state_d = GAP;
          end else if (cnt_q == 3'd7) begin
            err_d   = 1'b1;
            cnt_d   = 3'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (push) wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
    if (pop)  rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   lvl_d = lvl_q + LVL_W'(1);
      2'b01:   lvl_d = lvl_q - LVL_W'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      err_q   <= 1'b0;
      bcnt_q  <= '0;
      lvl_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      err_q   <= err_d;
      bcnt_q  <= bcnt_d;
      lvl_q   <= lvl_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_q] <= {rx_data, shreg_q};
  end

endmodule

// File: tb/tb_master_in_port.sv
// Bench for master_in_port: directed scenarios plus random frames against a queue model.
module tb_master_in_port;
  logic       clk = 1'b0;
  logic       reset, rx_data, slave_valid, slave_tx_done, rx_ready;
  logic       master_ready, rx_valid, frame_error;
  logic [7:0] rx_byte;
  logic [15:0] byte_count;
  logic [1:0] fifo_level;
  logic       mr4, rv4, fe4;
  logic [7:0] rb4;
  logic [3:0] bc4;
  logic [1:0] fl4;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int exp_cnt = 0;
  bit rand_pop = 0;

  always #5 clk = ~clk;

  master_in_port dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .slave_valid(slave_valid),
    .slave_tx_done(slave_tx_done), .master_ready(master_ready), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_error(frame_error),
    .byte_count(byte_count), .fifo_level(fifo_level)
  );

  master_in_port #(.DEPTH(2), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .slave_valid(slave_valid),
    .slave_tx_done(slave_tx_done), .master_ready(mr4), .rx_byte(rb4),
    .rx_valid(rv4), .rx_ready(rx_ready), .frame_error(fe4),
    .byte_count(bc4), .fifo_level(fl4)
  );

  // One clock of slave activity; the model pops its head whenever the consumer takes it.
  task automatic cyc(input logic v, input logic d, input logic dn);
    bit pop_now;
    slave_valid   = v;
    rx_data       = d;
    slave_tx_done = dn;
    if (rand_pop) rx_ready = 1'($urandom_range(0, 1));
    pop_now = rx_ready && (exp_q.size() != 0);
    @(posedge clk);
    if (pop_now) void'(exp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input int done_idx);
    for (int i = 0; i < n; i++) cyc(1'b1, b[i], i == done_idx);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_bits(b, 8, 7);
    exp_q.push_back(b);
    exp_cnt++;
  endtask

  task automatic linger();
    cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (master_ready !== 1'b0 || mr4 !== 1'b0) begin
      errors++; $display("FAIL reset_master_ready got %b/%b exp 0", master_ready, mr4);
    end
    checks++;
    if (rx_valid !== 1'b0 || rv4 !== 1'b0 || fifo_level !== 2'd0 || fl4 !== 2'd0) begin
      errors++; $display("FAIL reset_fifo got valid=%b level=%0d exp 0/0", rx_valid, fifo_level);
    end
    checks++;
    if (frame_error !== 1'b0 || fe4 !== 1'b0 || byte_count !== 16'd0 || bc4 !== 4'd0) begin
      errors++; $display("FAIL reset_err_cnt got fe=%b cnt=%0d exp 0/0", frame_error, byte_count);
    end
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (master_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_ready got %b exp 1", master_ready);
    end
  endtask

  task automatic test_single();
    rx_ready = 1'b0;
    send_good(8'hA5);
    checks++;
    if (rx_valid !== 1'b1 || rx_byte !== 8'hA5) begin
      errors++; $display("FAIL single_byte got valid=%b byte=%h exp 1/a5", rx_valid, rx_byte);
    end
    checks++;
    if (byte_count !== 16'd1 || fifo_level !== 2'd1 || frame_error !== 1'b0) begin
      errors++; $display("FAIL single_cnt got cnt=%0d level=%0d fe=%b exp 1/1/0",
                         byte_count, fifo_level, frame_error);
    end
    linger();
    rx_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0 || fifo_level !== 2'd0) begin
      errors++; $display("FAIL single_pop got valid=%b level=%0d exp 0/0", rx_valid, fifo_level);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] order [3];
    order[0] = 8'h01; order[1] = 8'h80; order[2] = 8'hFF;
    rx_ready = 1'b0;
    send_good(8'h01); linger();
    send_good(8'h80); linger();
    checks++;
    if (master_ready !== 1'b0 || fifo_level !== 2'd2) begin
      errors++; $display("FAIL full_ready got ready=%b level=%0d exp 0/2", master_ready, fifo_level);
    end
    cyc(1'b1, 1'b1, 1'b0);
    checks++;
    if (frame_error !== 1'b1 || fifo_level !== 2'd2 || byte_count !== 16'(exp_cnt)) begin
      errors++; $display("FAIL full_drop got fe=%b level=%0d cnt=%0d exp 1/2/%0d",
                         frame_error, fifo_level, byte_count, exp_cnt);
    end
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (frame_error !== 1'b0 || master_ready !== 1'b0) begin
      errors++; $display("FAIL full_stall got fe=%b ready=%b exp 0/0", frame_error, master_ready);
    end
    checks++;
    if (rx_byte !== order[0]) begin
      errors++; $display("FAIL order_0 got %h exp %h", rx_byte, order[0]);
    end
    rx_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    rx_ready = 1'b0;
    checks++;
    if (master_ready !== 1'b1 || fifo_level !== 2'd1) begin
      errors++; $display("FAIL after_pop got ready=%b level=%0d exp 1/1", master_ready, fifo_level);
    end
    send_good(8'hFF); linger();
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (rx_valid !== 1'b1 || rx_byte !== order[i]) begin
        errors++; $display("FAIL order_%0d got %b/%h exp 1/%h", i, rx_valid, rx_byte, order[i]);
      end
      rx_ready = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      rx_ready = 1'b0;
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL drained got valid=%b exp 0", rx_valid);
    end
  endtask

  task automatic test_drop();
    rx_ready = 1'b0;
    send_good(8'h5A); linger();
    send_bits(8'($urandom), 4, 8);
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (frame_error !== 1'b1 || fifo_level !== 2'd1 || master_ready !== 1'b1) begin
      errors++; $display("FAIL drop got fe=%b level=%0d ready=%b exp 1/1/1",
                         frame_error, fifo_level, master_ready);
    end
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (frame_error !== 1'b0) begin
      errors++; $display("FAIL drop_pulse got fe=%b exp 0", frame_error);
    end
  endtask

  task automatic test_early_done();
    rx_ready = 1'b0;
    send_bits(8'($urandom), 6, 5);
    checks++;
    if (frame_error !== 1'b1 || byte_count !== 16'(exp_cnt) || fifo_level !== 2'd1) begin
      errors++; $display("FAIL early_done got fe=%b cnt=%0d level=%0d exp 1/%0d/1",
                         frame_error, byte_count, fifo_level, exp_cnt);
    end
    linger();
    send_good(8'h3C); linger();
    rx_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    rx_ready = 1'b0;
    checks++;
    if (rx_byte !== 8'h3C || fifo_level !== 2'd1 || byte_count !== 16'(exp_cnt)) begin
      errors++; $display("FAIL after_early got byte=%h level=%0d cnt=%0d exp 3c/1/%0d",
                         rx_byte, fifo_level, byte_count, exp_cnt);
    end
    cyc(1'b0, 1'b0, 1'b1);
    checks++;
    if (frame_error !== 1'b1 || fifo_level !== 2'd1) begin
      errors++; $display("FAIL idle_done got fe=%b level=%0d exp 1/1", frame_error, fifo_level);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'($urandom);
    rx_ready = 1'b0;
    send_bits(b, 3, 8);
    reset = 1'b1;
    #1;
    checks++;
    if (master_ready !== 1'b0) begin
      errors++; $display("FAIL reset_mid_ready got %b exp 0", master_ready);
    end
    cyc(1'b1, b[3], 1'b0);
    exp_q.delete();
    exp_cnt = 0;
    checks++;
    if (rx_valid !== 1'b0 || fifo_level !== 2'd0 || byte_count !== 16'd0 || frame_error !== 1'b0) begin
      errors++; $display("FAIL reset_mid got valid=%b level=%0d cnt=%0d fe=%b exp 0/0/0/0",
                         rx_valid, fifo_level, byte_count, frame_error);
    end
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (master_ready !== 1'b1 || frame_error !== 1'b0) begin
      errors++; $display("FAIL reset_mid_after got ready=%b fe=%b exp 1/0", master_ready, frame_error);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    rx_ready = 1'b0;
    send_good(8'($urandom)); linger();
    for (int i = 1; i < 16; i++) begin
      b = 8'($urandom);
      send_bits(b, 7, 8);
      rx_ready = 1'b1;
      cyc(1'b1, b[7], 1'b1);
      rx_ready = 1'b0;
      exp_q.push_back(b);
      exp_cnt++;
      checks++;
      if (fifo_level !== 2'd1 || rx_byte !== b) begin
        errors++; $display("FAIL push_pop_%0d got level=%0d byte=%h exp 1/%h", i, fifo_level, rx_byte, b);
      end
      linger();
    end
    checks++;
    if (bc4 !== 4'd0 || byte_count !== 16'd16) begin
      errors++; $display("FAIL wrap got cnt4=%0d cnt16=%0d exp 0/16", bc4, byte_count);
    end
  endtask

  task automatic test_random();
    logic       fv [10];
    logic       fd [10];
    logic       fdn [10];
    logic       ferr [10];
    logic       fpush [10];
    logic [7:0] b;
    int nc, kind, n, guard;
    rand_pop = 1;
    for (int f = 0; f < 40; f++) begin
      guard = 0;
      while (master_ready !== 1'b1 && guard < 40) begin
        cyc(1'b0, 1'b0, 1'b0);
        guard++;
      end
      if (guard >= 40) begin
        checks++; errors++;
        $display("FAIL rand_ready_timeout f=%0d got ready=%b exp 1", f, master_ready);
        rand_pop = 0;
        return;
      end
      b = 8'($urandom);
      kind = $urandom_range(0, 3);
      for (int c = 0; c < 10; c++) begin
        fv[c] = 1'b0; fd[c] = 1'b0; fdn[c] = 1'b0; ferr[c] = 1'b0; fpush[c] = 1'b0;
      end
      case (kind)
        0: begin
          for (int c = 0; c < 8; c++) begin fv[c] = 1'b1; fd[c] = b[c]; end
          fdn[7] = 1'b1; fpush[7] = 1'b1;
          fv[8] = 1'b1; fd[8] = 1'($urandom_range(0, 1));
          nc = 9;
        end
        1: begin
          n = $urandom_range(1, 7);
          for (int c = 0; c < n; c++) begin fv[c] = 1'b1; fd[c] = b[c]; end
          ferr[n] = 1'b1;
          nc = n + 1;
        end
        2: begin
          n = $urandom_range(1, 6);
          for (int c = 0; c <= n; c++) begin fv[c] = 1'b1; fd[c] = b[c]; end
          fdn[n] = 1'b1; ferr[n] = 1'b1;
          fv[n+1] = 1'b1; fd[n+1] = 1'($urandom_range(0, 1)); fdn[n+1] = 1'($urandom_range(0, 1));
          nc = n + 2;
        end
        default: begin
          for (int c = 0; c < 8; c++) begin fv[c] = 1'b1; fd[c] = b[c]; end
          ferr[7] = 1'b1;
          nc = 9;
        end
      endcase
      for (int c = 0; c < nc; c++) begin
        cyc(fv[c], fd[c], fdn[c]);
        if (fpush[c]) begin exp_q.push_back(b); exp_cnt++; end
        checks++;
        if (frame_error !== ferr[c] || fe4 !== ferr[c]) begin
          errors++; $display("FAIL rand_fe f=%0d k=%0d c=%0d got %b/%b exp %b", f, kind, c, frame_error, fe4, ferr[c]);
        end
        checks++;
        if (fifo_level !== 2'(exp_q.size()) || fl4 !== 2'(exp_q.size()) ||
            rx_valid !== (exp_q.size() != 0) || rv4 !== (exp_q.size() != 0)) begin
          errors++; $display("FAIL rand_level f=%0d c=%0d got %0d/%b exp %0d", f, c, fifo_level, rx_valid, exp_q.size());
        end
        if (exp_q.size() != 0) begin
          checks++;
          if (rx_byte !== exp_q[0] || rb4 !== exp_q[0]) begin
            errors++; $display("FAIL rand_byte f=%0d c=%0d got %h exp %h", f, c, rx_byte, exp_q[0]);
          end
        end
        checks++;
        if (byte_count !== 16'(exp_cnt) || bc4 !== 4'(exp_cnt)) begin
          errors++; $display("FAIL rand_count f=%0d c=%0d got %0d/%0d exp %0d", f, c, byte_count, bc4, exp_cnt);
        end
      end
    end
    rand_pop = 0;
    rx_ready = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0 || mr4 !== 1'b1) begin
      errors++; $display("FAIL rand_drain got valid=%b ready4=%b exp 0/1", rx_valid, mr4);
    end
  endtask

  initial begin
    reset = 1'b1; rx_data = 1'b0; slave_valid = 1'b0; slave_tx_done = 1'b0; rx_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_drop();
    test_early_done();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
